// File: rtl/amba3_axi_slave_mem_pkg.sv
// Shared AXI3 types, state encodings and the burst next-address helper used by
// amba3_axi_slave_mem and amba3_axi_burst_addr.
package amba3_axi_slave_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_type_t;

    typedef enum logic [1:0] {
        LOCK_NORMAL    = 2'b00,
        LOCK_EXCLUSIVE = 2'b01,
        LOCK_LOCKED    = 2'b10,
        LOCK_RSVD      = 2'b11
    } lock_type_t;

    typedef logic [3:0] cache_attr_t;
    typedef logic [2:0] prot_attr_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_type_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    localparam int AXI_4KB = 4096;

    function automatic logic wrap_len_bad(input burst_type_t burst, input logic [3:0] len);
        return (burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
    endfunction

    // Addresses are handled 64 bits wide; callers truncate to their own width.
    // A WRAP with an illegal length and the reserved encoding both step like INCR.
    function automatic logic [63:0] amba3_axi_next_addr(input logic [63:0] addr,
                                                        input logic [3:0]  len,
                                                        input logic [2:0]  size,
                                                        input burst_type_t burst);
        logic [63:0] step;
        logic [63:0] aligned;
        logic [63:0] incr;
        logic [63:0] mask;
        step    = 64'd1 << size;
        aligned = addr & ~(step - 64'd1);
        incr    = aligned + step;
        mask    = ((64'(len) + 64'd1) << size) - 64'd1;
        if (burst == BURST_FIXED)
            return addr;
        else if (burst == BURST_WRAP && !wrap_len_bad(burst, len))
            return (aligned & ~mask) | (incr & mask);
        else
            return incr;
    endfunction

endpackage

// File: rtl/amba3_axi_burst_addr.sv
// Burst address generator: latches the start of a burst and walks its beat
// addresses, one instance per direction.
module amba3_axi_burst_addr
    import amba3_axi_slave_mem_pkg::*;
#(
    parameter int ADDR_SIZE = 32
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [3:0]           start_len,
    input  logic [2:0]           start_size,
    input  burst_type_t          start_burst,
    output logic [ADDR_SIZE-1:0] addr,
    output logic [ADDR_SIZE-1:0] next_addr,
    output logic [3:0]           beat,
    output logic [2:0]           size,
    output logic                 last,
    output logic                 next_last,
    output logic                 wrap_err
);

    logic [3:0]  len_q;
    burst_type_t burst_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            addr    <= '0;
            beat    <= '0;
            size    <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
        end else if (load) begin
            addr    <= start_addr;
            beat    <= '0;
            size    <= start_size;
            len_q   <= start_len;
            burst_q <= start_burst;
        end else if (advance) begin
            addr <= next_addr;
            beat <= beat + 4'd1;
        end
    end

    assign next_addr = ADDR_SIZE'(amba3_axi_next_addr(64'(addr), len_q, size, burst_q));
    assign last      = (beat == len_q);
    assign next_last = ((beat + 4'd1) == len_q);
    assign wrap_err  = wrap_len_bad(burst_q, len_q);

endmodule

// File: rtl/amba3_axi_slave_mem.sv
// AXI3 slave with on-chip word memory; one outstanding write and one outstanding read.
// Optional macro AMBA3_AXI_MEM_DECERR_EN: out-of-range addresses answer DECERR instead of aliasing.
module amba3_axi_slave_mem
    import amba3_axi_slave_mem_pkg::*;
#(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [TXID_SIZE-1:0]   awid,
    input  logic [ADDR_SIZE-1:0]   awaddr,
    input  logic [3:0]             awlen,
    input  logic [2:0]             awsize,
    input  burst_type_t            awburst,
    input  lock_type_t             awlock,
    input  cache_attr_t            awcache,
    input  prot_attr_t             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [TXID_SIZE-1:0]   wid,
    input  logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [TXID_SIZE-1:0]   bid,
    output resp_type_t             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [TXID_SIZE-1:0]   arid,
    input  logic [ADDR_SIZE-1:0]   araddr,
    input  logic [3:0]             arlen,
    input  logic [2:0]             arsize,
    input  burst_type_t            arburst,
    input  lock_type_t             arlock,
    input  cache_attr_t            arcache,
    input  prot_attr_t             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [TXID_SIZE-1:0]   rid,
    output logic [DATA_SIZE-1:0]   rdata,
    output resp_type_t             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int         STRB_SIZE = DATA_SIZE / 8;
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam int         LSB       = $clog2(STRB_SIZE);
    localparam logic [2:0] LSB_SZ    = 3'(LSB);

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     ready_en;

    logic [TXID_SIZE-1:0] w_id;
    logic                 w_err, w_dec, w_over;
    logic                 aw_hs, w_beat, w_beat_err, w_dec_beat, w_commit;
    logic [IDX_W-1:0]     w_idx;

    logic [ADDR_SIZE-1:0] wg_addr, wg_next_addr;
    logic [3:0]           wg_beat;
    logic [2:0]           wg_size;
    logic                 wg_last, wg_next_last, wg_wrap_err;

    logic                 ar_hs, r_adv, r_load, r_dec_beat, r_size_err, r_wrap_err, r_load_last;
    logic [ADDR_SIZE-1:0] r_load_addr;
    logic [2:0]           r_load_size;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_SIZE-1:0] r_word;

    logic [ADDR_SIZE-1:0] rg_addr, rg_next_addr;
    logic [3:0]           rg_beat;
    logic [2:0]           rg_size;
    logic                 rg_last, rg_next_last, rg_wrap_err;

    logic unused_ok;

    amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_wr_addr (
        .aclk(aclk), .areset_n(areset_n), .load(aw_hs), .advance(w_beat),
        .start_addr(awaddr), .start_len(awlen), .start_size(awsize), .start_burst(awburst),
        .addr(wg_addr), .next_addr(wg_next_addr), .beat(wg_beat), .size(wg_size),
        .last(wg_last), .next_last(wg_next_last), .wrap_err(wg_wrap_err)
    );

    amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_rd_addr (
        .aclk(aclk), .areset_n(areset_n), .load(ar_hs), .advance(r_adv),
        .start_addr(araddr), .start_len(arlen), .start_size(arsize), .start_burst(arburst),
        .addr(rg_addr), .next_addr(rg_next_addr), .beat(rg_beat), .size(rg_size),
        .last(rg_last), .next_last(rg_next_last), .wrap_err(rg_wrap_err)
    );

    // Handshakes stay off for the first cycle after reset release.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) ready_en <= 1'b0;
        else           ready_en <= 1'b1;
    end

`ifdef AMBA3_AXI_MEM_DECERR_EN
    assign w_dec_beat = |wg_addr[ADDR_SIZE-1:LSB+IDX_W];
    assign r_dec_beat = |r_load_addr[ADDR_SIZE-1:LSB+IDX_W];
`else
    assign w_dec_beat = 1'b0;
    assign r_dec_beat = 1'b0;
`endif

    // ---------------- write path ----------------
    assign aw_hs      = awvalid && awready;
    assign w_beat     = wvalid && wready;
    assign w_idx      = wg_addr[LSB +: IDX_W];
    assign w_beat_err = (wid != w_id) || (wlast != (wg_last && !w_over))
                        || (wg_size > LSB_SZ) || w_over;
    assign w_commit   = w_beat && !w_beat_err && !w_dec_beat;

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = ready_en;
                if (awvalid && ready_en) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_err   <= 1'b0;
            w_dec   <= 1'b0;
            w_over  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id   <= awid;
                w_err  <= 1'b0;
                w_dec  <= 1'b0;
                w_over <= 1'b0;
            end else if (w_beat) begin
                w_err <= w_err || w_beat_err || wg_wrap_err;
                w_dec <= w_dec || w_dec_beat;
                // Beats past len+1 without wlast keep flowing but are dropped.
                if (wg_last && !wlast) w_over <= 1'b1;
            end
        end
    end

    assign bid   = w_id;
    assign bresp = w_dec ? RESP_DECERR : (w_err ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge aclk) begin
        if (w_commit) begin
            for (int i = 0; i < STRB_SIZE; i++)
                if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    // ---------------- read path ----------------
    // Beat 0 comes straight from the AR channel, later beats from the generator's
    // look-ahead address, so consecutive beats issue without a bubble.
    assign ar_hs       = arvalid && arready;
    assign r_adv       = (r_state == R_DATA) && rvalid && rready && !rlast;
    assign r_load      = ar_hs || r_adv;
    assign r_load_addr = (r_state == R_IDLE) ? araddr : rg_next_addr;
    assign r_load_size = (r_state == R_IDLE) ? arsize : rg_size;
    assign r_wrap_err  = (r_state == R_IDLE) ? wrap_len_bad(arburst, arlen) : rg_wrap_err;
    assign r_load_last = (r_state == R_IDLE) ? (arlen == 4'd0) : rg_next_last;
    assign r_size_err  = r_load_size > LSB_SZ;
    assign r_idx       = r_load_addr[LSB +: IDX_W];
    assign r_word      = mem[r_idx];

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) r_next = R_DATA;
            end
            R_DATA: begin
                if (rvalid && rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) rid <= arid;
            if (r_load) begin
                rvalid <= 1'b1;
                rlast  <= r_load_last;
                rdata  <= (r_dec_beat || r_size_err) ? '0 : r_word;
                rresp  <= r_dec_beat ? RESP_DECERR :
                          ((r_size_err || r_wrap_err) ? RESP_SLVERR : RESP_OKAY);
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                         wg_addr, wg_next_addr, wg_next_last, wg_beat,
                         rg_addr, rg_beat, rg_last, r_load_addr};

endmodule
